// File: rtl/matmul_pkg.sv
// Shared constants, FSM state type and dimension record for the matrix multiply engine.
package matmul_pkg;

    localparam int unsigned DATA_W  = 4;
    localparam int unsigned DIM_W   = 4;
    localparam int unsigned MAX_DIM = 4;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned ACC_W   = 12;

    localparam logic [DIM_W-1:0] MAX_DIM_V = DIM_W'(MAX_DIM);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5
    } state_e;

    typedef struct packed {
        logic [DIM_W-1:0] r1;
        logic [DIM_W-1:0] c1;
        logic [DIM_W-1:0] r2;
        logic [DIM_W-1:0] c2;
    } dims_t;

    // Inner dimensions must agree and every dimension must lie in 1..MAX_DIM.
    function automatic logic dims_bad(input dims_t d);
        return (d.c1 != d.r2) ||
               (d.r1 == '0) || (d.c1 == '0) || (d.r2 == '0) || (d.c2 == '0) ||
               (d.r1 > MAX_DIM_V) || (d.c1 > MAX_DIM_V) ||
               (d.r2 > MAX_DIM_V) || (d.c2 > MAX_DIM_V);
    endfunction

endpackage

// File: rtl/matmul_if.sv
// Start/dimension inputs, A/B store read ports and result stream of the matrix multiply engine.
interface matmul_if;
    import matmul_pkg::*;

    logic              start;
    logic [DIM_W-1:0]  r1;
    logic [DIM_W-1:0]  c1;
    logic [DIM_W-1:0]  r2;
    logic [DIM_W-1:0]  c2;
    logic              a_rd_en;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              b_rd_en;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic [DIM_W-1:0]  res_row;
    logic [DIM_W-1:0]  res_col;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, r1, c1, r2, c2, a_data, b_data, res_ready,
        output a_rd_en, a_addr, b_rd_en, b_addr,
               res_valid, res_data, res_row, res_col, busy, done, err
    );

    modport slave (
        output start, r1, c1, r2, c2, a_data, b_data, res_ready,
        input  a_rd_en, a_addr, b_rd_en, b_addr,
               res_valid, res_data, res_row, res_col, busy, done, err
    );

endinterface

// File: rtl/matmul_addr_gen.sv
// Row/column/inner counters and row-major A/B store address generation.
module matmul_addr_gen
    import matmul_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  dims_t             dims_i,
    input  logic              clr_i,
    input  logic              k_inc_i,
    input  logic              adv_i,
    output logic [DIM_W-1:0]  i_o,
    output logic [DIM_W-1:0]  j_o,
    output logic [DIM_W-1:0]  k_o,
    output logic              k_last_o,
    output logic              last_elem_o,
    output logic [ADDR_W-1:0] a_addr_o,
    output logic [ADDR_W-1:0] b_addr_o
);

    logic [DIM_W-1:0] i_q, i_d;
    logic [DIM_W-1:0] j_q, j_d;
    logic [DIM_W-1:0] k_q, k_d;
    logic             j_wrap;

    assign j_wrap      = (j_q == dims_i.c2 - DIM_W'(1));
    assign last_elem_o = j_wrap && (i_q == dims_i.r1 - DIM_W'(1));
    assign k_last_o    = (k_q == dims_i.c1 - DIM_W'(1));

    always_comb begin
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        if (clr_i) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end else if (adv_i) begin
            k_d = '0;
            // Counters return to zero after the final element so idle outputs read 0.
            if (last_elem_o) begin
                i_d = '0;
                j_d = '0;
            end else if (j_wrap) begin
                j_d = '0;
                i_d = i_q + DIM_W'(1);
            end else begin
                j_d = j_q + DIM_W'(1);
            end
        end else if (k_inc_i) begin
            k_d = k_q + DIM_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
        end
    end

    assign a_addr_o = ADDR_W'(i_q) * ADDR_W'(dims_i.c1) + ADDR_W'(k_q);
    assign b_addr_o = ADDR_W'(k_q) * ADDR_W'(dims_i.c2) + ADDR_W'(j_q);
    assign i_o      = i_q;
    assign j_o      = j_q;
    assign k_o      = k_q;

endmodule

// File: rtl/matmul_engine.sv
// Single-MAC matrix multiplier streaming C = A x B in row-major order.
// Optional MATMUL_CYCLE_CNT_EN adds a saturating busy-cycle counter output.
module matmul_engine
    import matmul_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
`ifdef MATMUL_CYCLE_CNT_EN
    output logic [15:0] cycle_cnt,
`endif
    matmul_if.master    bus
);

    state_e              state_q, state_d;
    dims_t               dims_q, dims_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                err_q, err_d;
    logic                clr, k_inc, adv;
    logic [DIM_W-1:0]    i_cnt, j_cnt, k_cnt;
    logic                k_last, last_elem;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc_sum;

    matmul_addr_gen u_addr_gen (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .dims_i      (dims_q),
        .clr_i       (clr),
        .k_inc_i     (k_inc),
        .adv_i       (adv),
        .i_o         (i_cnt),
        .j_o         (j_cnt),
        .k_o         (k_cnt),
        .k_last_o    (k_last),
        .last_elem_o (last_elem),
        .a_addr_o    (bus.a_addr),
        .b_addr_o    (bus.b_addr)
    );

    assign prod    = {{DATA_W{1'b0}}, bus.a_data} * {{DATA_W{1'b0}}, bus.b_data};
    assign acc_sum = acc_q + ACC_W'(prod);

    always_comb begin
        state_d = state_q;
        dims_d  = dims_q;
        acc_d   = acc_q;
        err_d   = err_q;
        clr     = 1'b0;
        k_inc   = 1'b0;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dims_d  = '{r1: bus.r1, c1: bus.c1, r2: bus.r2, c2: bus.c2};
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (dims_bad(dims_q)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    clr     = 1'b1;
                    acc_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                // Store data lags the address by one cycle, so k==0 has nothing to add yet.
                k_inc = 1'b1;
                if (k_cnt != '0) acc_d = acc_sum;
                if (k_last) state_d = DRAIN;
            end
            DRAIN: begin
                acc_d   = acc_sum;
                state_d = OUT;
            end
            OUT: begin
                if (bus.res_ready) begin
                    adv     = 1'b1;
                    acc_d   = '0;
                    state_d = last_elem ? DONE : MAC;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            dims_q  <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dims_q  <= dims_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

    assign bus.a_rd_en   = (state_q == MAC);
    assign bus.b_rd_en   = (state_q == MAC);
    assign bus.res_valid = (state_q == OUT);
    assign bus.res_data  = acc_q;
    assign bus.res_row   = i_cnt;
    assign bus.res_col   = j_cnt;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = err_q;

`ifdef MATMUL_CYCLE_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            cnt_q <= '0;
        end else if (state_q != IDLE && cnt_q != '1) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_matmul_engine.sv
// Self-checking bench for matmul_engine against a plain-arithmetic matrix product model.
module tb_matmul_engine;
    import matmul_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matmul_if bus();

`ifdef MATMUL_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;
`endif

    matmul_engine dut (
        .CLK       (clk),
        .RST_N     (rst_n),
`ifdef MATMUL_CYCLE_CNT_EN
        .cycle_cnt (cycle_cnt),
`endif
        .bus       (bus)
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [DATA_W-1:0] a_mem [32];
    logic [DATA_W-1:0] b_mem [32];
    int unsigned       exp_c [4][4];
    logic [ADDR_W-1:0] aq [$];
    logic [ADDR_W-1:0] bq [$];

    // Element stores with one-cycle read latency, plus read/done monitors.
    always @(posedge clk) begin
        if (bus.a_rd_en) begin
            bus.a_data <= a_mem[bus.a_addr];
            aq.push_back(bus.a_addr);
        end
        if (bus.b_rd_en) begin
            bus.b_data <= b_mem[bus.b_addr];
            bq.push_back(bus.b_addr);
        end
        if (bus.done) done_cnt++;
    end

    task automatic compute_model(input int r1, input int c1, input int c2);
        for (int i = 0; i < r1; i++)
            for (int j = 0; j < c2; j++) begin
                int unsigned s = 0;
                for (int k = 0; k < c1; k++)
                    s += int'(a_mem[i*c1+k]) * int'(b_mem[k*c2+j]);
                exp_c[i][j] = s;
            end
    endtask

    task automatic fill_random();
        for (int n = 0; n < 32; n++) begin
            a_mem[n] = DATA_W'($urandom_range(0, 15));
            b_mem[n] = DATA_W'($urandom_range(0, 15));
        end
    endtask

    // Returns 1ns after the accepting rising edge.
    task automatic start_op(input int r1, input int c1, input int r2, input int c2);
        @(negedge clk);
        bus.r1    = DIM_W'(r1);
        bus.c1    = DIM_W'(c1);
        bus.r2    = DIM_W'(r2);
        bus.c2    = DIM_W'(c2);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic run_matmul(input int r1, input int c1, input int r2, input int c2,
                              input int stall_n);
        bit lat_bad = 0;
        int done_before;
        compute_model(r1, c1, c2);
        aq.delete();
        bq.delete();
        done_before = done_cnt;
        start_op(r1, c1, r2, c2);
        for (int cyc = 0; cyc <= c1 + 2; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                checks++;
                if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin
                    failures++;
                    $display("FAIL accept_state busy=%0b err=%0b required busy=1 err=0", bus.busy, bus.err);
                end
            end
            if (bus.res_valid !== (cyc == c1 + 2)) lat_bad = 1;
        end
        checks++;
        if (lat_bad) begin
            failures++;
            $display("FAIL latency res_valid=%0b after edge t+%0d, required first rise there only", bus.res_valid, c1 + 2);
        end
        for (int e = 0; e < r1 * c2; e++) begin
            int i = e / c2;
            int j = e % c2;
            int n = 0;
            while (bus.res_valid !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (bus.res_valid !== 1'b1) begin
                failures++;
                $display("FAIL result_timeout element=%0d res_valid=%0b required 1", e, bus.res_valid);
                return;
            end
            checks++;
            if (bus.res_data !== ACC_W'(exp_c[i][j]) || bus.res_row !== DIM_W'(i) || bus.res_col !== DIM_W'(j)) begin
                failures++;
                $display("FAIL result data=%0d row=%0d col=%0d required data=%0d row=%0d col=%0d",
                         bus.res_data, bus.res_row, bus.res_col, exp_c[i][j], i, j);
            end
            checks++;
            if (bus.a_rd_en !== 1'b0 || bus.b_rd_en !== 1'b0) begin
                failures++;
                $display("FAIL out_strobes a_rd_en=%0b b_rd_en=%0b required 0", bus.a_rd_en, bus.b_rd_en);
            end
            if (e == 0 && stall_n > 0) begin
                bit bad = 0;
                bus.res_ready = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    if (bus.res_valid !== 1'b1 || bus.res_data !== ACC_W'(exp_c[0][0]) ||
                        bus.a_rd_en !== 1'b0 || bus.b_rd_en !== 1'b0) bad = 1;
                end
                checks++;
                if (bad) begin
                    failures++;
                    $display("FAIL stall_hold valid=%0b data=%0d rd=%0b required valid=1 data=%0d rd=0",
                             bus.res_valid, bus.res_data, bus.a_rd_en, exp_c[0][0]);
                end
                bus.res_ready = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL done_pulse done=%0b busy=%0b required done=1 busy=1", bus.done, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || done_cnt != done_before + 1) begin
            failures++;
            $display("FAIL done_end done=%0b busy=%0b pulses=%0d required done=0 busy=0 pulses=1",
                     bus.done, bus.busy, done_cnt - done_before);
        end
    endtask

    task automatic load_2x2();
        a_mem[0] = 4'd1; a_mem[1] = 4'd2; a_mem[2] = 4'd3; a_mem[3] = 4'd4;
        b_mem[0] = 4'd5; b_mem[1] = 4'd6; b_mem[2] = 4'd7; b_mem[3] = 4'd8;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.res_ready = 1'b1;
        bus.r1 = '0; bus.c1 = '0; bus.r2 = '0; bus.c2 = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 0 || bus.done !== 0 || bus.err !== 0 || bus.res_valid !== 0 ||
            bus.a_rd_en !== 0 || bus.b_rd_en !== 0 || bus.res_data !== '0 ||
            bus.a_addr !== '0 || bus.b_addr !== '0 || bus.res_row !== '0 || bus.res_col !== '0) begin
            failures++;
            $display("FAIL reset_outputs busy=%0b valid=%0b data=%0d a_addr=%0d required all 0",
                     bus.busy, bus.res_valid, bus.res_data, bus.a_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_2x2();
        load_2x2();
        run_matmul(2, 2, 2, 2, 0);
`ifdef MATMUL_CYCLE_CNT_EN
        checks++;
        if (cycle_cnt !== 16'd18) begin
            failures++;
            $display("FAIL cycle_cnt got=%0d required=18", cycle_cnt);
        end
`endif
    endtask

    task automatic test_dim_error();
        int rd_before = aq.size();
        bit bad = 0;
        start_op(2, 3, 2, 2);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL dim_err err=%0b busy=%0b required err=1 busy=0", bus.err, bus.busy);
        end
        repeat (4) begin
            @(negedge clk);
            if (bus.res_valid !== 0 || bus.err !== 1) bad = 1;
        end
        checks++;
        if (bad || aq.size() != rd_before || bus.b_rd_en !== 0) begin
            failures++;
            $display("FAIL dim_err_quiet reads=%0d valid=%0b err=%0b required reads=0 valid=0 err=1",
                     aq.size() - rd_before, bus.res_valid, bus.err);
        end
    endtask

    task automatic test_stall();
        load_2x2();
        run_matmul(2, 2, 2, 2, 5);
    endtask

    task automatic test_all_max();
        for (int n = 0; n < 16; n++) begin
            a_mem[n] = 4'hF;
            b_mem[n] = 4'hF;
        end
        run_matmul(4, 4, 4, 4, 0);
    endtask

    task automatic test_1x3();
        bit bad = 0;
        a_mem[0] = 4'd1; a_mem[1] = 4'd2; a_mem[2] = 4'd3;
        b_mem[0] = 4'd4; b_mem[1] = 4'd5; b_mem[2] = 4'd6;
        run_matmul(1, 3, 3, 1, 0);
        if (aq.size() != 3 || bq.size() != 3) bad = 1;
        else
            for (int n = 0; n < 3; n++)
                if (aq[n] !== ADDR_W'(n) || bq[n] !== ADDR_W'(n)) bad = 1;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL addr_seq a_reads=%0d b_reads=%0d required 3 reads each at 0,1,2", aq.size(), bq.size());
        end
    endtask

    task automatic test_reset_mid();
        int done_before = done_cnt;
        load_2x2();
        start_op(2, 2, 2, 2);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 0 || bus.a_rd_en !== 0 || bus.b_rd_en !== 0 || bus.res_valid !== 0 ||
            bus.done !== 0 || bus.res_data !== '0 || bus.a_addr !== '0 || bus.b_addr !== '0) begin
            failures++;
            $display("FAIL async_reset busy=%0b rd=%0b a_addr=%0d b_addr=%0d required all 0",
                     bus.busy, bus.a_rd_en, bus.a_addr, bus.b_addr);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (done_cnt != done_before || bus.busy !== 0) begin
            failures++;
            $display("FAIL reset_no_done pulses=%0d busy=%0b required pulses=0 busy=0", done_cnt - done_before, bus.busy);
        end
        run_matmul(2, 2, 2, 2, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 5; t++) begin
            int r1 = $urandom_range(1, 4);
            int c1 = $urandom_range(1, 4);
            int c2 = $urandom_range(1, 4);
            fill_random();
            run_matmul(r1, c1, c1, c2, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_basic_2x2();
        test_dim_error();
        test_stall();
        test_all_max();
        test_1x3();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time exceeded");
        $fatal(1);
    end

endmodule

// File: doc/matmul_engine.md
Name: matmul_engine

Overview:
Downstream consumer of the nibble-stream matrix loader.
- After the loader has captured dimensions R1/C1/R2/C2 and the element stores for matrix 1 (A) and matrix 2 (B), a start pulse makes this block read both stores and compute C = A x B.
- It uses one multiply-accumulate per cycle.
- Result elements stream out in row-major order over a valid/ready handshake.

Parameters:
- DATA_W, 4, element width (matches loader nibble)
- DIM_W, 4, width of each dimension field
- MAX_DIM, 4, largest legal row/column count
- ADDR_W, 5, store address width
- ACC_W, 12, accumulator/result width (holds 4 x 15 x 15 = 900)

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  reset, asynchronous, active-low
- start  in  1  begin computation; sampled only in IDLE
- r1, c1, r2, c2  in  DIM_W each  dimensions; latched on start accept
- a_rd_en  out  1  read strobe to A store
- a_addr  out  ADDR_W  A address, row-major i*c1+k
- a_data  in  DATA_W  A element; valid 1 cycle after a_rd_en
- b_rd_en  out  1  read strobe to B store
- b_addr  out  ADDR_W  B address, row-major k*c2+j
- b_data  in  DATA_W  B element; valid 1 cycle after b_rd_en
- res_valid  out  1  result element available
- res_ready  in  1  consumer accepts result
- res_data  out  ACC_W  C[i][j]
- res_row, res_col  out  DIM_W each  indices of res_data
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after the last result handshake
- err  out  1  dimension error; held until next accepted start

Behaviour:
- Reset (RST_N low, async): state IDLE. All outputs, counters i/j/k, accumulator and latched dimensions are 0. err is cleared.
- Reset mid-operation aborts immediately. No partial done is produced.

States:
- IDLE: on start=1 → latch dims, clear err, go to CHECK. start in any other state is ignored.
- CHECK (1 cycle): error if c1!=r2, or any dim==0, or any dim>MAX_DIM. On error → err=1, go to IDLE. Otherwise i=j=k=0, acc=0, go to MAC.
- MAC (c1 cycles):
  - a_rd_en and b_rd_en are high, with addresses formed from the current i/j/k.
  - The product of the data returned for the previous k is added to acc.
  - k increments. After issuing k=c1-1 → DRAIN.
- DRAIN (1 cycle): add the last product. Read strobes are low. → OUT.
- OUT:
  - res_valid=1 with res_data=acc, res_row=i, res_col=j. These values are stable until the handshake.
  - On res_valid & res_ready: acc=0, k=0, j++.
  - When j wraps at c2: j=0, i++.
  - After the (r1-1, c2-1) handshake → DONE. Otherwise → MAC.
- DONE (1 cycle): done=1, → IDLE.

Arithmetic and timing:
- Arithmetic is unsigned. The product is 2*DATA_W bits, zero-extended to ACC_W. No overflow is possible within the parameter limits.
- Latency: if start is accepted at edge t, res_valid first rises after edge t+c1+2.
- Throughput: c1+2 cycles per element when res_ready is held high.
- Read strobes are never asserted outside MAC, including during OUT stalls.

Optional Feature:
MATMUL_CYCLE_CNT_EN
- Defined: adds output cycle_cnt [15:0].
  - Cleared on start accept.
  - Increments every cycle while busy, including stall cycles; saturates at 0xFFFF.
  - Holds its value in IDLE until the next start. Reset value is 0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package matmul_pkg holds:
  - state enum (IDLE, CHECK, MAC, DRAIN, OUT, DONE)
  - DATA_W/DIM_W/ADDR_W/ACC_W/MAX_DIM default constants
  - a dims struct {r1,c1,r2,c2}
- One sub-module, matmul_addr_gen:
  - owns the i/j/k counters, the wrap and last-element flags, and the a_addr/b_addr computation.
  - The top level holds the FSM, multiplier and accumulator.

Test Plan:
- 2x2 x 2x2, A=[1,2,3,4], B=[5,6,7,8], res_ready=1 → results 19, 22, 43, 50 at (0,0),(0,1),(1,0),(1,1), then a single done pulse; busy falls the cycle after done.
- r1=2, c1=3, r2=2, c2=2 → err=1 two cycles after start; no read strobes, no res_valid; busy back to 0.
- Same as the first case, with res_ready low for 5 cycles at the first result → res_valid held, res_data=19 stable, a_rd_en/b_rd_en low throughout the stall; remaining results unchanged.
- 4x4 x 4x4, all elements 15 → 16 results, each 900; last at (3,3).
- 1x3 x 3x1, A=[1,2,3], B=[4,5,6] → res_data=32; res_valid rises after edge t+5 relative to the start-accept edge t; a_addr sequence 0,1,2; b_addr sequence 0,1,2.
- Assert RST_N low during MAC of the 2x2 case → all outputs 0 asynchronously, no done; after release, rerun the 2x2 case with correct results. With MATMUL_CYCLE_CNT_EN defined, cycle_cnt=18 after an unstalled 2x2 run.
